// File: rtl/seven_seg_scanner.sv
// Multiplexed N-digit seven-segment scanner with hex mode and leading-zero blanking.
// Optional per-slot brightness control via SEVEN_SEG_BRIGHTNESS_EN (adds Duty input).
module seven_seg_scanner #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned SEG_ACTIVE_LOW = 0,
    parameter int unsigned DIG_ACTIVE_LOW = 1
) (
    input  logic                  Clk,
    input  logic                  nReset,
    input  logic [4*DIGITS-1:0]   BCD,
    input  logic                  Load,
    input  logic                  HexMode,
    input  logic                  Blank,
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    input  logic [3:0]            Duty,
`endif
    output logic [6:0]            Segments,
    output logic [DIGITS-1:0]     Anodes
);

    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                run_q, run_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    logic [3:0]          duty_q, duty_d;
`endif

    logic [3:0]          nib;
    logic                zero_above;
    logic [DIGITS-1:0]   lead_zero;
    logic                lz_sel;
    logic [DIGITS-1:0]   onehot;
    logic                an_on;
    logic [6:0]          seg_raw;

    // Active-high gfedcba glyphs; 10..15 only lit in hex mode
    function automatic logic [6:0] decode(input logic [3:0] v, input logic hex);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b0111111;
            4'h1: g = 7'b0000110;
            4'h2: g = 7'b1011011;
            4'h3: g = 7'b1001111;
            4'h4: g = 7'b1100110;
            4'h5: g = 7'b1101101;
            4'h6: g = 7'b1111101;
            4'h7: g = 7'b0000111;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1101111;
            4'hA: g = hex ? 7'b1110111 : 7'b0000000;
            4'hB: g = hex ? 7'b1111100 : 7'b0000000;
            4'hC: g = hex ? 7'b0111001 : 7'b0000000;
            4'hD: g = hex ? 7'b1011110 : 7'b0000000;
            4'hE: g = hex ? 7'b1111001 : 7'b0000000;
            default: g = hex ? 7'b1110001 : 7'b0000000;
        endcase
        return g;
    endfunction

    always_comb begin
        shadow_d = Load ? BCD : shadow_q;
        run_d    = 1'b1;
        pre_d    = pre_q;
        idx_d    = idx_q;
        // Counting starts one cycle after reset release so the first slot lands on edge 2
        if (run_q) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end

        zero_above = 1'b1;
        lead_zero  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above & (shadow_q[4*i +: 4] == 4'h0);
            lead_zero[i] = zero_above;
        end

        nib    = 4'h0;
        lz_sel = 1'b0;
        onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib       = shadow_q[4*i +: 4];
                lz_sel    = lead_zero[i] && (i != 0);
                onehot[i] = 1'b1;
            end
        end

        seg_raw = (Blank && lz_sel) ? 7'b0000000 : decode(nib, HexMode);
        an_on   = (pre_q != PRE_LAST);
`ifdef SEVEN_SEG_BRIGHTNESS_EN
        duty_d = (pre_q == '0) ? Duty : duty_q;
        an_on  = an_on && (32'(pre_q) < (32'(duty_d) + 32'd1) * (CLK_DIV / 16));
`endif

        seg_d = SEG_OFF;
        an_d  = DIG_OFF;
        if (run_q) begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
            an_d  = an_on ? ((DIG_ACTIVE_LOW != 0) ? ~onehot : onehot) : DIG_OFF;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            shadow_q <= '0;
            pre_q    <= '0;
            idx_q    <= '0;
            run_q    <= 1'b0;
            seg_q    <= SEG_OFF;
            an_q     <= DIG_OFF;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
            duty_q   <= 4'hF;
`endif
        end else begin
            shadow_q <= shadow_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            run_q    <= run_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
            duty_q   <= duty_d;
`endif
        end
    end

    assign Segments = seg_q;
    assign Anodes   = an_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner (DIGITS=4, CLK_DIV=16): time-based reference model plus directed literals.
module tb_seven_seg_scanner;

    logic        Clk = 1'b0;
    logic        nReset;
    logic [15:0] BCD;
    logic        Load;
    logic        HexMode;
    logic        Blank;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    logic [3:0]  Duty = 4'hF;
`endif
    logic [6:0]  Segments;
    logic [3:0]  Anodes;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    seven_seg_scanner #(.DIGITS(4), .CLK_DIV(16)) dut (
        .Clk      (Clk),
        .nReset   (nReset),
        .BCD      (BCD),
        .Load     (Load),
        .HexMode  (HexMode),
        .Blank    (Blank),
`ifdef SEVEN_SEG_BRIGHTNESS_EN
        .Duty     (Duty),
`endif
        .Segments (Segments),
        .Anodes   (Anodes)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] glyph(input logic [3:0] v, input logic hex);
        case (v)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return hex ? 7'b1110111 : 7'b0;
            4'hB: return hex ? 7'b1111100 : 7'b0;
            4'hC: return hex ? 7'b0111001 : 7'b0;
            4'hD: return hex ? 7'b1011110 : 7'b0;
            4'hE: return hex ? 7'b1111001 : 7'b0;
            default: return hex ? 7'b1110001 : 7'b0;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input logic [15:0] sh, input int d,
                                             input logic hex, input logic blk);
        logic [15:0] upper;
        upper = sh >> (4 * d);
        if (blk && d != 0 && upper == 16'h0) return 7'b0;
        return glyph(upper[3:0], hex);
    endfunction

    // Reference: edges since reset release define slot and position directly
    int          n_edges = 0;
    logic [15:0] m_shadow = '0;
    logic [6:0]  exp_seg = '0;
    logic [3:0]  exp_an = 4'hF;

    always @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            n_edges  = 0;
            m_shadow = '0;
            exp_seg  = '0;
            exp_an   = 4'hF;
        end else begin
            n_edges++;
            if (n_edges >= 2) begin
                int t, pos, d;
                t   = n_edges - 2;
                pos = t % 16;
                d   = (t / 16) % 4;
                exp_an  = (pos == 15) ? 4'hF : ~(4'(1) << d);
                exp_seg = model_seg(m_shadow, d, HexMode, Blank);
            end
            if (Load) m_shadow = BCD;
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            vectors++;
            if (Segments !== exp_seg || Anodes !== exp_an) begin
                errors++;
                $display("FAIL cycle_compare t=%0t seg=%b want %b an=%b want %b",
                         $time, Segments, exp_seg, Anodes, exp_an);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic load(input logic [15:0] v);
        BCD  = v;
        Load = 1'b1;
        step(1);
        Load = 1'b0;
        step(1);
    endtask

    task automatic wait_digit(input int d, output bit found);
        logic [3:0] pat;
        pat   = ~(4'(1) << d);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge Clk);
            if (Anodes === pat) found = 1'b1;
        end
    endtask

    task automatic find_check(input string name, input int d, input logic [6:0] want);
        bit found;
        wait_digit(d, found);
        if (!found) begin
            vectors++;
            errors++;
            $display("FAIL %s timeout waiting for digit %0d got an=%b", name, d, Anodes);
        end else begin
            chk(name, 32'(Segments), 32'(want));
        end
    endtask

    task automatic release_check(input string tag);
        nReset = 1'b1;
        @(posedge Clk); #1;
        chk({tag, "_edge1_an"}, 32'(Anodes), 32'(4'b1111));
        @(posedge Clk); #1;
        chk({tag, "_edge2_an"}, 32'(Anodes), 32'(4'b1110));
        repeat (14) @(posedge Clk);
        #1;
        chk({tag, "_edge16_an"}, 32'(Anodes), 32'(4'b1110));
        @(posedge Clk); #1;
        chk({tag, "_dead_an"}, 32'(Anodes), 32'(4'b1111));
        @(posedge Clk); #1;
        chk({tag, "_digit1_an"}, 32'(Anodes), 32'(4'b1101));
        #1;
    endtask

    initial begin
        bit found;
        nReset = 1'b0; Load = 1'b0; BCD = '0; HexMode = 1'b0; Blank = 1'b0;
        step(3);
        chk("reset_seg", 32'(Segments), 32'(7'b0));
        chk("reset_an", 32'(Anodes), 32'(4'b1111));
        chk_en = 1'b1;
        release_check("por");

        load(16'h1234);
        find_check("h1234_d0", 0, 7'b1100110);
        find_check("h1234_d1", 1, 7'b1001111);
        find_check("h1234_d2", 2, 7'b1011011);
        find_check("h1234_d3", 3, 7'b0000110);

        // Asynchronous reset in the middle of a slot
        step(7);
        #1;
        nReset = 1'b0;
        #1;
        chk("midrst_seg", 32'(Segments), 32'(7'b0));
        chk("midrst_an", 32'(Anodes), 32'(4'b1111));
        step(2);
        release_check("midrst");

        Blank = 1'b1;
        load(16'h0007);
        find_check("blank7_d3", 3, 7'b0);
        find_check("blank7_d2", 2, 7'b0);
        find_check("blank7_d1", 1, 7'b0);
        find_check("blank7_d0", 0, 7'b0000111);
        load(16'h0000);
        find_check("blank0_d0", 0, 7'b0111111);
        find_check("blank0_d1", 1, 7'b0);
        Blank = 1'b0;

        HexMode = 1'b1;
        load(16'h00AF);
        find_check("hex_d1", 1, 7'b1110111);
        find_check("hex_d0", 0, 7'b1110001);
        HexMode = 1'b0;
        find_check("nohex_d1", 1, 7'b0);
        find_check("nohex_d0", 0, 7'b0);

        // Load pulse during digit 2: exactly two-edge latency
        load(16'h1234);
        wait_digit(2, found);
        chk("t5_found", 32'(found), 32'(1));
        @(posedge Clk); #2;
        BCD  = 16'h0800;
        Load = 1'b1;
        @(posedge Clk); #1;
        chk("t5_edge1_seg", 32'(Segments), 32'(7'b1011011));
        #1;
        Load = 1'b0;
        @(posedge Clk); #1;
        chk("t5_edge2_seg", 32'(Segments), 32'(7'b1111111));
        chk("t5_edge2_an", 32'(Anodes), 32'(4'b1011));
        #1;
        find_check("t5_d0", 0, 7'b0111111);

        // Randomized traffic with a bias toward leading zeros
        for (int c = 0; c < 1500; c++) begin
            step(1);
            if ($urandom_range(0, 15) == 0) begin
                BCD  = 16'($urandom) >> (4 * $urandom_range(0, 4));
                Load = 1'b1;
            end else begin
                Load = 1'b0;
            end
            if ($urandom_range(0, 40) == 0) HexMode = ~HexMode;
            if ($urandom_range(0, 40) == 0) Blank = ~Blank;
        end
        Load = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
